// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam int UART_DEF_DIV = 2604;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; dout always presents the head word.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Same index with differing wrap bits means the write side has lapped the read side.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Configurable-frame UART transmitter fed by a word FIFO; queued words go out
// back-to-back with no idle gap between frames.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int      CLK_DIV    = UART_DEF_DIV,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_start,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_rdy,
  output logic                          tx_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          tx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);

  tx_state_t            state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, fifo_dout;
  logic                 par_bit, par_bit_n, tx_n;
  logic                 bit_end, load, full, empty;

  assign bit_end = (baud_cnt == CW'(CLK_DIV - 1));
  assign tx_rdy  = !full;
  assign tx_busy = (state != IDLE) || !empty;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_start && tx_rdy),
    .pop   (load),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    tx_n       = tx;
    load       = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        tx_n       = 1'b1;
        load       = !empty;
      end
      START: if (bit_end) begin
        state_n   = DATA;
        bit_idx_n = '0;
        tx_n      = shreg[0];
        shreg_n   = shreg >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_idx == IW'(DATA_BITS - 1)) begin
          bit_idx_n = '0;
          state_n   = (PARITY != PAR_NONE) ? PAR : STOP;
          tx_n      = (PARITY != PAR_NONE) ? par_bit : 1'b1;
        end else begin
          bit_idx_n = bit_idx + 1'b1;
          tx_n      = shreg[0];
          shreg_n   = shreg >> 1;
        end
      end
      PAR: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_idx == IW'(STOP_BITS - 1)) begin
          load    = !empty;
          state_n = IDLE;
        end else begin
          bit_idx_n = bit_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Pop and load share one edge; parity is taken from the unshifted word.
    if (load) begin
      state_n    = START;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
      shreg_n    = fifo_dout;
      par_bit_n  = (^fifo_dout) ^ (PARITY == PAR_ODD);
      tx_n       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      tx       <= tx_n;
      overflow <= tx_start && !tx_rdy;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: four frame configurations, a line decoder per
// instance, and a scoreboard of words expected on the wire.
module tb_uart_tx_fifo_cfg;
  import uart_pkg::*;

  localparam int      DBS [4] = '{8, 7, 7, 9};
  localparam parity_t PMS [4] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
  localparam int      SBS [4] = '{1, 2, 2, 1};

  typedef struct packed {
    logic [15:0] raw;
    logic [8:0]  data;
    logic        par;
    logic        stop_ok;
    logic        clean;
    logic [15:0] gap;
  } rx_t;

  typedef struct {
    int         g;
    logic [8:0] d;
  } exp_t;

  logic            clk, rst;
  logic [3:0]      start_v, rdy_v, busy_v, ovf_v, tx_v;
  logic [3:0][8:0] data_v;
  logic [3:0][2:0] cnt_v;

  int   checks = 0, failures = 0;
  int   rd [4] = '{0, 0, 0, 0};
  exp_t exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int DB = DBS[g];
    localparam int PB = (PMS[g] != PAR_NONE) ? 1 : 0;
    localparam int NB = 1 + DB + PB + SBS[g];
    rx_t rx [64];
    int  wr = 0;
    int  edges = 0;

    uart_tx_fifo_cfg #(
      .CLK_DIV(16), .DATA_BITS(DB), .PARITY(PMS[g]), .STOP_BITS(SBS[g]), .FIFO_DEPTH(4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_start (start_v[g]),
      .tx_data  (data_v[g][DB-1:0]),
      .tx_rdy   (rdy_v[g]),
      .tx_busy  (busy_v[g]),
      .overflow (ovf_v[g]),
      .fifo_cnt (cnt_v[g]),
      .tx       (tx_v[g])
    );

    // Line decoder: latches each bit at its first cycle and flags any change within the bit.
    initial begin : mon
      int          cyc, gcyc, last_end;
      bit          active;
      logic        bv, prev, clean;
      logic [15:0] fb;
      rx_t         r;
      cyc = 0; gcyc = 0; last_end = -1000; active = 0;
      bv = 1'b1; prev = 1'b1; clean = 1'b1; fb = '0; r = '0;
      forever begin
        @(negedge clk);
        gcyc++;
        if (tx_v[g] !== prev) edges++;
        prev = tx_v[g];
        if (rst) active = 0;
        else if (!active) begin
          if (tx_v[g] == 1'b0) begin
            active = 1; cyc = 0; fb = '0; clean = 1'b1;
            r.gap = 16'(gcyc - last_end - 1);
          end
        end else cyc++;
        if (active && !rst) begin
          if (cyc % 16 == 0) begin
            bv = tx_v[g];
            fb[cyc/16] = bv;
          end else if (tx_v[g] !== bv) clean = 1'b0;
          if (cyc == NB*16 - 1) begin
            r.raw = fb;
            r.data = '0;
            for (int i = 0; i < DB; i++) r.data[i] = fb[i+1];
            r.par = (PB != 0) ? fb[DB+1] : 1'b0;
            r.stop_ok = 1'b1;
            for (int i = 1 + DB + PB; i < NB; i++) if (fb[i] !== 1'b1) r.stop_ok = 1'b0;
            r.clean = clean;
            rx[wr % 64] = r;
            wr++;
            active = 0;
            last_end = gcyc;
          end
        end
      end
    end
  end

  function automatic int get_wr(input int g);
    case (g)
      0: return gi[0].wr;
      1: return gi[1].wr;
      2: return gi[2].wr;
      default: return gi[3].wr;
    endcase
  endfunction

  function automatic rx_t get_rx(input int g, input int k);
    case (g)
      0: return gi[0].rx[k % 64];
      1: return gi[1].rx[k % 64];
      2: return gi[2].rx[k % 64];
      default: return gi[3].rx[k % 64];
    endcase
  endfunction

  function automatic logic exp_par(input int g, input logic [8:0] d);
    logic p = 1'b0;
    for (int i = 0; i < DBS[g]; i++) p ^= d[i];
    return (PMS[g] == PAR_ODD) ? ~p : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [8:0] d, input bit acc);
    start_v[g] = 1'b1;
    data_v[g]  = d;
    if (acc) exp_q.push_back('{g, d});
    @(posedge clk); #1;
    start_v[g] = 1'b0;
  endtask

  task automatic expect_frame(input bit last, output rx_t r);
    exp_t e;
    int   t;
    e = exp_q.pop_front();
    t = 0;
    while (get_wr(e.g) <= rd[e.g] && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    assert (get_wr(e.g) > rd[e.g]) else begin
      failures++;
      $error("FAIL frame_timeout inst=%0d observed=none expected=%0h", e.g, e.d);
    end
    r = get_rx(e.g, rd[e.g]);
    rd[e.g]++;
    chk("frame_data", 32'(r.data), 32'(e.d));
    if (PMS[e.g] != PAR_NONE) chk("frame_par", 32'(r.par), 32'(exp_par(e.g, e.d)));
    chk("frame_stop", 32'(r.stop_ok), 1);
    chk("frame_bitlen", 32'(r.clean), 1);
    if (last) begin
      chk("idle_busy", 32'(busy_v[e.g]), 0);
      chk("idle_tx", 32'(tx_v[e.g]), 1);
    end
  endtask

  initial begin
    rx_t r;
    int  w0, e0;
    rst = 1'b1; start_v = '0; data_v = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_tx", 32'(tx_v), 32'hF);
    chk("reset_rdy", 32'(rdy_v), 32'hF);
    chk("reset_busy", 32'(busy_v), 0);
    chk("reset_ovf", 32'(ovf_v), 0);
    chk("reset_cnt", 32'(cnt_v), 0);

    // 8N1 single word: start bit one edge after the push edge
    start_v[0] = 1'b1; data_v[0] = 9'h0A5; exp_q.push_back('{0, 9'h0A5});
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("lat_tx_hi", 32'(tx_v[0]), 1);
    chk("lat_busy", 32'(busy_v[0]), 1);
    chk("lat_cnt", 32'(cnt_v[0]), 1);
    @(posedge clk); #1;
    chk("lat_tx_lo", 32'(tx_v[0]), 0);
    chk("lat_cnt_pop", 32'(cnt_v[0]), 0);
    expect_frame(1'b1, r);
    chk("8n1_bits", 32'(r.raw[9:0]), 32'({1'b1, 8'hA5, 1'b0}));

    // 7E2 and 7O2 with the same word
    push(1, 9'h003, 1'b1);
    expect_frame(1'b1, r);
    chk("7e2_par", 32'(r.par), 0);
    push(2, 9'h003, 1'b1);
    expect_frame(1'b1, r);
    chk("7o2_par", 32'(r.par), 1);

    // 9N1 back-to-back
    push(3, 9'h1FF, 1'b1);
    push(3, 9'h000, 1'b1);
    push(3, 9'h155, 1'b1);
    expect_frame(1'b0, r);
    expect_frame(1'b0, r);
    chk("b2b_gap2", 32'(r.gap), 0);
    expect_frame(1'b1, r);
    chk("b2b_gap3", 32'(r.gap), 0);

    // Overflow: one word in flight, four buffered, sixth dropped
    w0 = get_wr(0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("ovf_rdy", 32'(rdy_v[0]), 0);
        chk("ovf_cnt_full", 32'(cnt_v[0]), 4);
        chk("ovf_pre", 32'(ovf_v[0]), 0);
      end
      push(0, 9'(8'h10 + i), i < 5);
    end
    chk("ovf_pulse", 32'(ovf_v[0]), 1);
    @(posedge clk); #1;
    chk("ovf_post", 32'(ovf_v[0]), 0);
    for (int i = 0; i < 5; i++) expect_frame(i == 4, r);
    repeat (200) @(posedge clk); #1;
    chk("ovf_frames", get_wr(0) - w0, 5);

    // Push on the edge where the last stop period ends with one word queued
    push(0, 9'h03C, 1'b1);
    push(0, 9'h0C3, 1'b1);
    chk("sim_cnt_pre", 32'(cnt_v[0]), 1);
    repeat (159) @(posedge clk); #1;
    chk("sim_cnt_stop", 32'(cnt_v[0]), 1);
    chk("sim_tx_stop", 32'(tx_v[0]), 1);
    start_v[0] = 1'b1; data_v[0] = 9'h05A; exp_q.push_back('{0, 9'h05A});
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("sim_cnt_post", 32'(cnt_v[0]), 1);
    chk("sim_tx_start", 32'(tx_v[0]), 0);
    expect_frame(1'b0, r);
    expect_frame(1'b0, r);
    chk("sim_gap_b", 32'(r.gap), 0);
    expect_frame(1'b1, r);
    chk("sim_gap_c", 32'(r.gap), 0);

    // Reset during a start bit with three words queued
    push(0, 9'h011, 1'b0);
    push(0, 9'h022, 1'b0);
    push(0, 9'h033, 1'b0);
    push(0, 9'h044, 1'b0);
    chk("rstq_cnt", 32'(cnt_v[0]), 3);
    chk("rstq_tx", 32'(tx_v[0]), 0);
    w0 = get_wr(0);
    #2; rst = 1'b1; #1;
    chk("rstm_tx", 32'(tx_v[0]), 1);
    chk("rstm_cnt", 32'(cnt_v[0]), 0);
    chk("rstm_rdy", 32'(rdy_v[0]), 1);
    chk("rstm_busy", 32'(busy_v[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    e0 = gi[0].edges;
    repeat (300) @(posedge clk); #1;
    chk("rstm_edges", gi[0].edges, e0);
    chk("rstm_frames", get_wr(0), w0);
    chk("rstm_idle_tx", 32'(tx_v[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
# uart_tx_fifo_cfg

Parametrised UART transmitter with a write-side FIFO. It serialises words onto `tx` using a configurable frame: 5–9 data bits sent LSB first, optional even or odd parity, and 1 or 2 stop bits, at a fixed integer clock divisor. It is the general-purpose serial output for the design. Unlike the fixed 8N1 transmitter, it buffers up to `FIFO_DEPTH` words and sends them back-to-back with no idle gap between frames.

## Interface
- `CLK_DIV`, default 2604: clock cycles per bit period. Legal range ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–9.
- `PARITY`, default `PAR_NONE`: parity mode, of type `uart_pkg::parity_t`. Values are `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, default 4: word buffer depth. Must be a power of 2, ≥ 2.
- `clk` input 1: the single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_start` input 1: write strobe. Pushes `tx_data` into the FIFO.
- `tx_data` input DATA_BITS: word to send.
- `tx_rdy` output 1: FIFO not full.
- `tx_busy` output 1: a frame is in progress or the FIFO is non-empty.
- `overflow` output 1: one-cycle pulse when a write is dropped.
- `fifo_cnt` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** on an edge where `tx_start` = 1 and `tx_rdy` = 1, the word is written. If `tx_start` = 1 and `tx_rdy` = 0, the word is dropped and `overflow` = 1 for the following cycle.
- **Push when full:** `tx_rdy` is the registered full flag. A push while full is dropped even if a pop happens on the same edge.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
- **IDLE:** holds `tx` = 1. When the FIFO is non-empty, it pops the head word into the shift register, drives `tx` to 0 and moves to START. Pop and load happen on the same edge.
- **START → DATA:** after one bit period. The data-bit index is cleared.
- **DATA:** on each bit-period end, `tx` takes the next data bit (LSB first). After DATA_BITS bits, go to PAR if `PARITY` ≠ `PAR_NONE`, else to STOP.
- **PAR:** `tx` = XOR of the data bits for `PAR_EVEN`, and its inverse for `PAR_ODD`. Moves to STOP after one bit period.
- **STOP:** `tx` = 1 for `STOP_BITS` bit periods. At the end of the last stop period:
  - if the FIFO is non-empty, pop and enter START directly, with `tx` going to 0 on that same edge;
  - otherwise go to IDLE.
- **Baud counter:** width $clog2(CLK_DIV). It is cleared in IDLE and on every load. A bit period ends when count = CLK_DIV−1, at which point the count wraps to 0.
- **Parity computation:** computed from the word as loaded, not from the partially shifted register.
- **Simultaneous push and pop:** allowed. `fifo_cnt` is unchanged.
- **Push into an empty FIFO while in IDLE:** the word is popped on the next edge. It is not bypassed combinationally.
- **Reset mid-frame:** the frame is abandoned and the FIFO is emptied. `tx` returns to 1 asynchronously.

## Timing
- **Reset values:** `tx` = 1, `tx_rdy` = 1, `tx_busy` = 0, `overflow` = 0, `fifo_cnt` = 0. FSM is in IDLE, baud counter and bit index are 0.
- **Latency:** a push at edge N into an empty FIFO while idle gives `tx` = 0 from edge N+1.
- **Bit period:** every bit, including start, parity and each stop bit, lasts exactly CLK_DIV cycles.
- **Frame length:** CLK_DIV × (1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) cycles.
- **Back-to-back frames:** zero idle cycles between the last stop bit and the next start bit.
- **`tx`:** registered, with no combinational path from any input.
- **`tx_busy`:** asserted from the edge after an accepted push until `tx` returns high in IDLE with the FIFO empty.

## Structure
- **Package `uart_pkg`:**
  - `parity_t` enum;
  - `tx_state_t` enum {IDLE, START, DATA, PAR, STOP};
  - constant `UART_DEF_DIV` = 2604.
- **Sub-module `uart_sync_fifo`:** parameters WIDTH and DEPTH; ports clk, rst, push, pop, din, dout, full, empty, count.
  - Registered pointers with one extra wrap bit.
  - `dout` always shows the head word.
  - Pop when empty and push when full are ignored.
- **Top level:** the FSM, baud counter, bit index, shift register and parity register.

## Test plan
- **Reset:** assert `rst` mid-frame with CLK_DIV = 16 and 3 words queued → `tx` = 1 immediately, `fifo_cnt` = 0, `tx_rdy` = 1, and no further edges on `tx`.
- **8N1 single word:** CLK_DIV = 16, push 0xA5 → `tx` goes low one cycle later. The sampled bit sequence is 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles long, then `tx_busy` = 0.
- **Parity and stop bits:** DATA_BITS = 7, PAR_EVEN, STOP_BITS = 2, push 0x03 → parity bit 0 and two 1-periods of stop. With PAR_ODD, the same word gives parity bit 1.
- **Back-to-back:** 9-bit mode, push 0x1FF, 0x000, 0x155 on consecutive cycles → three contiguous frames with 0 gap cycles, decoded as the same values in order.
- **Overflow:** FIFO_DEPTH = 4, push 6 words in 6 cycles while the first frame is running:
  - the first word is popped, the next 4 fill the FIFO;
  - the 6th push sees `tx_rdy` = 0 and gives an `overflow` pulse of exactly 1 cycle;
  - exactly 5 frames are sent.
- **Simultaneous push and pop:** push on the exact edge where a STOP period ends with `fifo_cnt` = 1 → `fifo_cnt` stays 1, the next frame starts with no gap, and the pushed word is sent after it.
